// File: rtl/sram_word_controller_if.sv
// Upstream store-access handshake: single-word read/write requests on ready/req,
// with a one-cycle done pulse and held read data on the return path.
interface sram_word_controller_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  ready;
   logic                  done;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output req, we, addr, wdata, input ready, done, rdata);
   modport slave  (input req, we, addr, wdata, output ready, done, rdata);
endinterface

// File: rtl/sram_word_controller.sv
// Control sequencer for a bank of 2114 1Kx4 SRAMs forming one wide store word:
// holds CS_n/WE_n phases for parameterised clock counts and owns the data bus only during the write pulse.
module sram_word_controller #(
   parameter int ADDR_WIDTH         = 10,
   parameter int DATA_WIDTH         = 32,
   parameter int READ_WAIT_CYCLES   = 5,
   parameter int WRITE_PULSE_CYCLES = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   sram_word_controller_if.slave bus,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   inout  wire  [DATA_WIDTH-1:0] sram_dq,
   output logic                  sram_cs_n,
   output logic                  sram_we_n
);
   localparam int RD_EFF  = (READ_WAIT_CYCLES   < 1) ? 1 : READ_WAIT_CYCLES;
   localparam int WP_EFF  = (WRITE_PULSE_CYCLES < 1) ? 1 : WRITE_PULSE_CYCLES;
   localparam int CNT_MAX = (RD_EFF > WP_EFF) ? RD_EFF : WP_EFF;
   localparam int CW      = ($clog2(CNT_MAX + 1) < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] RD_LOAD = CW'(RD_EFF);
   localparam logic [CW-1:0] WP_LOAD = CW'(WP_EFF);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   if (DATA_WIDTH % 4 != 0) begin : g_bad_width
      $error("sram_word_controller: DATA_WIDTH must be a multiple of 4");
   end

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WSETUP, S_WPULSE} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CW-1:0]         r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_done;
   logic                  w_accept;
   logic                  w_cnt_last;
   logic                  w_ready;
   logic                  w_cs_n;
   logic                  w_we_n;
   logic                  w_dq_oe;

   assign w_accept   = bus.req && (r_state == S_IDLE);
   assign w_cnt_last = (r_cnt == CNT_ONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept)   w_next = bus.we ? S_WSETUP : S_READ;
         S_READ:   if (w_cnt_last) w_next = S_IDLE;
         S_WSETUP:                 w_next = S_WPULSE;
         S_WPULSE: if (w_cnt_last) w_next = S_IDLE;
         default:                  w_next = S_IDLE;
      endcase
   end

   // Strobes decode straight from the state register, so reset releases the bank immediately.
   always_comb begin
      w_ready = 1'b0;
      w_cs_n  = 1'b0;
      w_we_n  = 1'b1;
      w_dq_oe = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            w_cs_n  = 1'b1;
         end
         S_WPULSE: begin
            w_we_n  = 1'b0;
            w_dq_oe = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr  <= bus.addr;
                  r_wdata <= bus.wdata;
                  r_cnt   <= RD_LOAD;
               end
            end
            S_READ: begin
               r_cnt <= r_cnt - CNT_ONE;
               if (w_cnt_last) begin
                  r_rdata <= sram_dq;
                  r_done  <= 1'b1;
               end
            end
            S_WSETUP: r_cnt <= WP_LOAD;
            S_WPULSE: begin
               r_cnt <= r_cnt - CNT_ONE;
               if (w_cnt_last) r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.ready = w_ready;
   assign bus.done  = r_done;
   assign bus.rdata = r_rdata;
   assign sram_addr = r_addr;
   assign sram_cs_n = w_cs_n;
   assign sram_we_n = w_we_n;
   assign sram_dq   = w_dq_oe ? r_wdata : {DATA_WIDTH{1'bz}};
endmodule
